// File: rtl/mem_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_initiator_pkg
// Description : Shared types and helpers for the memory-protocol initiator.
//               Holds the FSM state encoding and the function that sizes the
//               rvalid timeout counter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_initiator_pkg;

  // Transaction phases: accept command, hold request until granted,
  // wait for rvalid, present response until consumed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Counter must be able to hold TIMEOUT_CYCLES itself so it can saturate there.
  function automatic int timeout_cnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_initiator.sv
`default_nettype none
// ============================================================================
// Module      : mem_initiator
// Description : Single-outstanding bus master for the req/gnt/rvalid memory
//               protocol. Accepts one command over a valid/ready handshake,
//               issues it as a memory request, waits (bounded) for rvalid and
//               returns the result over a valid/ready response handshake.
//               Responses arriving outside the wait phase raise a sticky flag.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o  command handshake
//   cmd_addr_i/we/be/wdata   command fields, captured on handshake
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_rdata_o, rsp_err_o   read data (0 for writes/timeouts), timeout flag
//   stray_o                  sticky: rvalid seen while not waiting for one
//   req_o, gnt_i             memory request / grant (gnt may depend on req)
//   addr_o/we_o/be_o/wdata_o registered request fields
//   rvalid_i, rdata_i        memory response
// Revision    : 1.0 - initial release
// ============================================================================
module mem_initiator
  import mem_initiator_pkg::*;
#(
  parameter int ADDR_WIDTH     = 22,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255   // must be >= 1
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic                    cmd_we_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,

  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    stray_o,

  output logic                    req_o,
  input  logic                    gnt_i,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic                    we_o,
  output logic [DATA_WIDTH/8-1:0] be_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  input  logic                    rvalid_i,
  input  logic [DATA_WIDTH-1:0]   rdata_i
);

  localparam int                   CNT_WIDTH = timeout_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;

  // Handshake strobes depend on state only, so no input reaches an output
  // combinationally (gnt_i may legally be derived from req_o).
  assign cmd_ready_o = (r_state == IDLE);
  assign req_o       = (r_state == REQ);
  assign rsp_valid_o = (r_state == RESP);

  // Saturating increment: holds at TIMEOUT_CYCLES rather than wrapping.
  assign w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  // r_cnt is cleared on grant and counts WAIT cycles already spent, so
  // w_cnt_next is the ordinal of the current WAIT cycle. The timeout fires
  // on the TIMEOUT_CYCLES-th WAIT cycle if rvalid has not shown up by then;
  // an rvalid in that same cycle still takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      addr_o      <= '0;
      we_o        <= 1'b0;
      be_o        <= '0;
      wdata_o     <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      stray_o     <= 1'b0;
    end else begin
      // Any response not expected right now (incl. late ones after a
      // timeout) is dropped and remembered until reset.
      if (rvalid_i && (r_state != WAIT)) begin
        stray_o <= 1'b1;
      end

      unique case (r_state)
        IDLE: begin
          if (cmd_valid_i) begin
            addr_o  <= cmd_addr_i;
            we_o    <= cmd_we_i;
            be_o    <= cmd_be_i;
            wdata_o <= cmd_wdata_i;
            r_state <= REQ;
          end
        end

        // Request is never withdrawn and has no timeout of its own.
        REQ: begin
          if (gnt_i) begin
            r_cnt   <= '0;
            r_state <= WAIT;
          end
        end

        WAIT: begin
          r_cnt <= w_cnt_next;
          if (rvalid_i) begin
            rsp_rdata_o <= we_o ? '0 : rdata_i;
            rsp_err_o   <= 1'b0;
            r_state     <= RESP;
          end else if (w_cnt_next == CNT_MAX) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b1;
            r_state     <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_initiator
// Description : Self-checking bench for mem_initiator. A RAM responder with
//               programmable grant/rvalid behaviour drives the memory side; a
//               transaction-timestamp model predicts every output each cycle,
//               and directed steps pin the model with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_initiator;

  localparam int AW  = 22;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid_i, cmd_ready_o;
  logic [AW-1:0] cmd_addr_i;
  logic          cmd_we_i;
  logic [BW-1:0] cmd_be_i;
  logic [DW-1:0] cmd_wdata_i;
  logic          rsp_valid_o, rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o, stray_o;
  logic          req_o, gnt_i;
  logic [AW-1:0] addr_o;
  logic          we_o;
  logic [BW-1:0] be_o;
  logic [DW-1:0] wdata_o;
  logic          rvalid_i;
  logic [DW-1:0] rdata_i;

  mem_initiator #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i (cmd_addr_i),
    .cmd_we_i   (cmd_we_i),
    .cmd_be_i   (cmd_be_i),
    .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .stray_o    (stray_o),
    .req_o      (req_o),
    .gnt_i      (gnt_i),
    .addr_o     (addr_o),
    .we_o       (we_o),
    .be_o       (be_o),
    .wdata_o    (wdata_o),
    .rvalid_i   (rvalid_i),
    .rdata_i    (rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // ---------------------------------------------------------------- RAM side
  logic [DW-1:0] mem [int];
  logic          gnt_en;
  logic          rv_drop;
  int            rv_lat;
  logic          inject;

  assign gnt_i = req_o & gnt_en;

  function automatic logic [DW-1:0] mem_rd(input int a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  initial begin : responder
    int            cd;
    logic          g, gwe, drop, inj;
    logic [AW-1:0] ga;
    logic [BW-1:0] gbe;
    logic [DW-1:0] gwd, pend, tmp;
    int            lat;
    cd = 0; pend = '0;
    rvalid_i = 1'b0; rdata_i = '0;
    forever begin
      @(negedge clk);
      g = req_o && gnt_i; ga = addr_o; gwe = we_o; gbe = be_o; gwd = wdata_o;
      drop = rv_drop; lat = rv_lat; inj = inject; inject = 1'b0;
      @(posedge clk); #1;
      rvalid_i = 1'b0; rdata_i = '0;
      if (g) begin
        if (gwe) begin
          tmp = mem_rd(int'(ga));
          for (int b = 0; b < BW; b++) if (gbe[b]) tmp[8*b +: 8] = gwd[8*b +: 8];
          mem[int'(ga)] = tmp;
          pend = '1;            // junk data on write responses must be masked
        end else begin
          pend = mem_rd(int'(ga));
        end
        cd = drop ? 0 : lat;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin rvalid_i = 1'b1; rdata_i = pend; end
      end
      if (inj) begin rvalid_i = 1'b1; rdata_i = 32'h1234_5678; end
    end
  end

  // ------------------------------------------------------------------ model
  // One transaction at a time, described by timestamps: acceptance, grant
  // cycle, first response cycle. Outputs are derived from those each cycle.
  initial begin : model
    logic          m_armed, m_active, m_stray, m_we, m_err;
    int            m_gnt, m_rsp;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_be;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          e_ready, e_req, e_rv;
    m_armed = 0; m_active = 0; m_stray = 0; m_we = 0; m_err = 0;
    m_gnt = -1; m_rsp = -1; m_addr = '0; m_be = '0; m_wdata = '0; m_rdata = '0;
    forever begin
      @(negedge clk);
      e_ready = !m_active;
      e_req   = m_active && (m_gnt < 0);
      e_rv    = m_active && (m_rsp >= 0) && (cyc >= m_rsp);
      if (m_armed) begin
        chk("cmd_ready", cmd_ready_o, e_ready);
        chk("req", req_o, e_req);
        chk("rsp_valid", rsp_valid_o, e_rv);
        if (e_rv) begin
          chk("rsp_rdata", rsp_rdata_o, m_rdata);
          chk("rsp_err", rsp_err_o, m_err);
        end
        chk("stray", stray_o, m_stray);
        chk("addr", addr_o, m_addr);
        chk("we", we_o, m_we);
        chk("be", be_o, m_be);
        chk("wdata", wdata_o, m_wdata);
      end
      if (rvalid_i) begin
        if (m_active && m_gnt >= 0 && cyc > m_gnt && m_rsp < 0) begin
          m_rsp = cyc + 1; m_err = 0; m_rdata = m_we ? '0 : rdata_i;
        end else begin
          m_stray = 1;
        end
      end else if (m_active && m_gnt >= 0 && m_rsp < 0 && cyc == m_gnt + TMO) begin
        m_rsp = cyc + 1; m_err = 1; m_rdata = '0;
      end
      if (e_req && gnt_i) m_gnt = cyc;
      if (e_rv && rsp_ready_i) m_active = 0;
      if (e_ready && cmd_valid_i) begin
        m_active = 1; m_gnt = -1; m_rsp = -1;
        m_addr = cmd_addr_i; m_we = cmd_we_i; m_be = cmd_be_i; m_wdata = cmd_wdata_i;
      end
      if (rst) begin
        m_armed = 1; m_active = 0; m_stray = 0; m_gnt = -1; m_rsp = -1;
        m_addr = '0; m_we = 0; m_be = '0; m_wdata = '0; m_rdata = '0; m_err = 0;
      end
    end
  end

  // ----------------------------------------------------------------- tasks
  // Called just after a rising edge; returns just after the rising edge that
  // follows the command handshake. n = handshake cycle.
  task automatic do_cmd(input logic [AW-1:0] a, input logic we, input logic [BW-1:0] be,
                        input logic [DW-1:0] wd, output int n);
    cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_we_i = we; cmd_be_i = be; cmd_wdata_i = wd;
    n = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready_o) begin n = cyc; break; end
    end
    if (n < 0) chk("cmd_accept_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  // Returns at the falling edge of the first cycle with rsp_valid_o high.
  task automatic wait_rsp(output int r);
    r = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid_o) begin r = cyc; break; end
    end
    if (r < 0) chk("rsp_wait_timeout", 0, 1);
  endtask

  // Full transaction with rsp_ready held high; checks latency when exp_lat>=0.
  task automatic txn(input string nm, input logic [AW-1:0] a, input logic we,
                     input logic [BW-1:0] be, input logic [DW-1:0] wd, input int exp_lat,
                     input logic [DW-1:0] exp_rd, input logic exp_err, output int n, output int r);
    do_cmd(a, we, be, wd, n);
    rsp_ready_i = 1'b1;
    wait_rsp(r);
    if (exp_lat >= 0) chk({nm, "_latency"}, r - n, exp_lat);
    chk({nm, "_rdata"}, rsp_rdata_o, exp_rd);
    chk({nm, "_err"}, rsp_err_o, exp_err);
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
  endtask

  task automatic chk_reset_values(input string nm);
    chk({nm, "_cmd_ready"}, cmd_ready_o, 1);
    chk({nm, "_req"}, req_o, 0);
    chk({nm, "_rsp_valid"}, rsp_valid_o, 0);
    chk({nm, "_rsp_err"}, rsp_err_o, 0);
    chk({nm, "_rsp_rdata"}, rsp_rdata_o, 0);
    chk({nm, "_stray"}, stray_o, 0);
    chk({nm, "_addr"}, addr_o, 0);
    chk({nm, "_we"}, we_o, 0);
    chk({nm, "_be"}, be_o, 0);
    chk({nm, "_wdata"}, wdata_o, 0);
  endtask

  // ----------------------------------------------------------------- main
  initial begin : main
    int n, r, n2, r2;
    rst = 1'b1; cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_we_i = 1'b0; cmd_be_i = '0;
    cmd_wdata_i = '0; rsp_ready_i = 1'b0;
    gnt_en = 1'b1; rv_drop = 1'b0; rv_lat = 1; inject = 1'b0;
    mem[32'h10] = 32'hDEAD_BEEF;
    mem[32'h30] = 32'h0BAD_F00D;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_values("reset");
    @(posedge clk); #1;

    // Minimum-latency read: response three cycles after the handshake.
    txn("rd_10", 22'h10, 1'b0, 4'hF, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, n, r);

    // Partial write then read back; second command accepted right after.
    txn("wr_20", 22'h20, 1'b1, 4'b0011, 32'hA5A5_A5A5, 3, 32'h0, 1'b0, n, r);
    txn("rd_20", 22'h20, 1'b0, 4'hF, 32'h0, 3, 32'h0000_A5A5, 1'b0, n2, r2);
    chk("back_to_back_accept", n2, r + 1);

    // Grant withheld for five cycles: request held for six.
    gnt_en = 1'b0;
    do_cmd(22'h30, 1'b0, 4'hF, 32'h0, n);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("stall_req", req_o, 1);
      chk("stall_addr", addr_o, 22'h30);
      if (i == 5) begin @(posedge clk); #1; gnt_en = 1'b1; end
    end
    @(negedge clk);
    chk("stall_req_dropped", req_o, 0);
    rsp_ready_i = 1'b1;
    wait_rsp(r);
    chk("stall_rdata", rsp_rdata_o, 32'h0BAD_F00D);
    chk("stall_err", rsp_err_o, 0);
    @(posedge clk); #1; rsp_ready_i = 1'b0;

    // Timeout: grant at n+1, fourth WAIT cycle at n+5, error response at n+6.
    rv_drop = 1'b1;
    txn("timeout", 22'h44, 1'b0, 4'hF, 32'h0, 1 + TMO + 1, 32'h0, 1'b1, n, r);
    rv_drop = 1'b0;
    inject  = 1'b1;               // late rvalid lands two cycles after the handshake
    @(negedge clk); chk("stray_pre1", stray_o, 0);
    @(negedge clk); chk("stray_pre2", stray_o, 0);
    @(negedge clk); chk("stray_set", stray_o, 1);
    @(posedge clk); #1;
    txn("after_stray", 22'h10, 1'b0, 4'hF, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, n, r);
    chk("stray_sticky", stray_o, 1);

    // Response back-pressure: held stable, no new command accepted.
    do_cmd(22'h10, 1'b0, 4'hF, 32'h0, n);
    wait_rsp(r);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid_o, 1);
      chk("hold_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
      chk("hold_cmd_ready", cmd_ready_o, 0);
    end
    @(posedge clk); #1; rsp_ready_i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; rsp_ready_i = 1'b0;
    @(negedge clk);
    chk("ready_after_rsp", cmd_ready_o, 1);
    @(posedge clk); #1;

    // Reset in the middle of REQ.
    gnt_en = 1'b0;
    do_cmd(22'h55, 1'b1, 4'hF, 32'hCAFE_BABE, n);
    @(negedge clk);
    chk("pre_rst_req", req_o, 1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk_reset_values("mid_req_rst");
    gnt_en = 1'b1;
    @(posedge clk); #1;
    txn("recover", 22'h30, 1'b0, 4'hF, 32'h0, 3, 32'h0BAD_F00D, 1'b0, n, r);
    chk("cancelled_write", mem_rd(32'h55), 32'h0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks %0d errors %0d)", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mem_initiator.md
# mem_initiator

Bus master for the core's memory request protocol (req/gnt/rvalid with addr, we, be, wdata, rdata), driving the same port a RI5CY data or instruction port would drive into the RAM wrapper. It lets testbench loaders, debug logic and self-test sequencers issue single read/write transactions through a simple command/response handshake. It keeps at most one transaction outstanding, has an rvalid timeout, and flags stray responses.

## Interface
- ADDR_WIDTH, 22, memory address width (matches the RAM wrapper).
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits.
- TIMEOUT_CYCLES, 255, cycles waited for rvalid after gnt before error; must be ≥1.
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command accepted when valid&&ready.
- cmd_addr_i  in  ADDR_WIDTH  target address.
- cmd_we_i  in  1  1=write, 0=read.
- cmd_be_i  in  DATA_WIDTH/8  byte enables.
- cmd_wdata_i  in  DATA_WIDTH  write data.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed when valid&&ready.
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err_o  out  1  rvalid timeout occurred.
- stray_o  out  1  sticky: rvalid seen outside WAIT; cleared only by rst.
- req_o  out  1  memory request.
- gnt_i  in  1  request granted; may be combinational from req_o.
- addr_o, we_o, be_o, wdata_o  out  ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  registered request fields.
- rvalid_i  in  1  response valid; at least one cycle after gnt.
- rdata_i  in  DATA_WIDTH  read data, valid with rvalid_i.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: cmd_ready_o=1. On handshake, register the command fields onto addr_o/we_o/be_o/wdata_o and go to REQ.
- REQ: req_o=1, request fields held stable. On gnt_i go to WAIT and clear the timeout counter; otherwise stay in REQ indefinitely. There is no timeout in REQ, and req is never withdrawn.
- WAIT: req_o=0. The counter increments each cycle.
  - On rvalid_i: capture rdata_i (or 0 if we_o=1), set err=0, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES with no rvalid_i: rdata=0, err=1, go to RESP.
  - If rvalid_i and the timeout coincide, rvalid_i wins.
- RESP: rsp_valid_o=1; rsp_rdata_o and rsp_err_o held stable. On rsp_ready_i go to IDLE.
- An rvalid_i in IDLE, REQ or RESP is ignored for data and sets stray_o. This covers late responses after a timeout.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

## Timing
- Reset values: state=IDLE; cmd_ready_o=1 the cycle after reset. req_o, rsp_valid_o, rsp_err_o, stray_o, we_o = 0; addr_o, be_o, wdata_o, rsp_rdata_o = 0.
- rst asserted in any state returns to IDLE next cycle and drops req_o, even mid-REQ. A pending response is discarded.
- Minimum latency with gnt same-cycle and rvalid one cycle later:
  - cmd handshake at cycle N;
  - req_o=1 at N+1, granted at N+1;
  - rvalid at N+2;
  - rsp_valid_o=1 at N+3.
- Back-to-back: cmd_ready_o rises the cycle after the response handshake. Throughput is at most one transaction per 4 cycles.
- All outputs are registered or decoded from state only; there is no combinational input-to-output path.

## Structure
- A shared package holds the state enum typedef (IDLE/REQ/WAIT/RESP) and the function returning the timeout counter width.
- No sub-module required; the FSM and saturating counter live in one module.
- The FSM plus counter is ~150–250 lines of RTL.

## Test plan
- Read, RAM model with immediate gnt and 1-cycle rvalid, preloaded 0xDEADBEEF at addr 0x10 -> rsp_valid_o at N+3, rsp_rdata_o=0xDEADBEEF, rsp_err_o=0.
- Write 0xA5A5A5A5, be=4'b0011, addr 0x20, then read 0x20 from a zero-initialised RAM -> second response rdata=0x0000A5A5; first response rdata=0.
- Grant held off 5 cycles -> req_o and addr_o stable for 6 cycles; response correct; no error.
- Model never returns rvalid, TIMEOUT_CYCLES=4 -> rsp_err_o=1 and rdata=0, four cycles after gnt. An rvalid injected 2 cycles later sets stray_o=1 and does not disturb the next transaction.
- rsp_ready_i held low 10 cycles -> response held stable, cmd_ready_o=0 throughout. rst pulsed during REQ -> req_o=0 next cycle, all outputs at reset values.
